// File: rtl/cfg_readback_serializer.sv
// cfg_readback_serializer: splits a 512-bit config word into four 128-bit valid/ready beats
module cfg_readback_serializer #(
  parameter int CNT_W = 16
) (
  input  logic             I_sys_clk,
  input  logic             I_sys_rst_n,
  input  logic             I_clr,
  input  logic [511:0]     I_word_value,
  input  logic             I_word_valid,
  output logic             O_word_ready,
  output logic [127:0]     O_cfg_data,
  output logic             O_cfg_data_valid,
  input  logic             I_cfg_data_ready,
  output logic             O_cfg_data_last,
  output logic             O_word_done,
  output logic [CNT_W-1:0] O_word_cnt
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [511:0] sr_q, sr_d;
  logic [1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign O_word_ready     = state_q == IDLE;
  assign O_cfg_data_valid = state_q == SEND;
  assign O_cfg_data       = sr_q[511:384];
  assign O_cfg_data_last  = (state_q == SEND) && (idx_q == 2'd3);
  assign O_word_done      = state_q == DONE;
  assign O_word_cnt       = cnt_q;
  // state, shift register, beat index and word counter
  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state; clear overrides every handshake and discards any word in flight
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (I_clr) begin
      state_d = IDLE;
      sr_d    = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (I_word_valid) begin
          sr_d    = I_word_value;
          idx_d   = '0;
          state_d = SEND;
        end
        SEND: if (I_cfg_data_ready) begin
          sr_d  = {sr_q[383:0], 128'b0};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = DONE;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cfg_readback_serializer.sv
// tb_cfg_readback_serializer: randomized self-checking bench against a word/beat reference model
module tb_cfg_readback_serializer;
  localparam int CW = 4;
  logic I_sys_clk = 0;
  logic I_sys_rst_n = 0;
  logic I_clr = 0;
  logic [511:0] I_word_value = '0;
  logic I_word_valid = 0;
  logic O_word_ready;
  logic [127:0] O_cfg_data;
  logic O_cfg_data_valid;
  logic I_cfg_data_ready = 0;
  logic O_cfg_data_last;
  logic O_word_done;
  logic [CW-1:0] O_word_cnt;
  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  cfg_readback_serializer #(.CNT_W(CW)) dut (
    .I_sys_clk(I_sys_clk), .I_sys_rst_n(I_sys_rst_n), .I_clr(I_clr),
    .I_word_value(I_word_value), .I_word_valid(I_word_valid), .O_word_ready(O_word_ready),
    .O_cfg_data(O_cfg_data), .O_cfg_data_valid(O_cfg_data_valid),
    .I_cfg_data_ready(I_cfg_data_ready), .O_cfg_data_last(O_cfg_data_last),
    .O_word_done(O_word_done), .O_word_cnt(O_word_cnt)
  );

  always #5 I_sys_clk = ~I_sys_clk;

  function automatic logic [127:0] beat(input logic [511:0] w, input int k);
    return w[511-128*k -: 128];
  endfunction

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic tick();
    @(posedge I_sys_clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (O_word_ready !== 1'b1 || O_cfg_data_valid !== 1'b0 || O_cfg_data_last !== 1'b0 ||
        O_word_done !== 1'b0 || O_cfg_data !== 128'h0 || O_word_cnt !== CW'(0)) begin
      failures++;
      $display("FAIL reset: rdy=%b vld=%b last=%b done=%b data=%h cnt=%0d, want 1 0 0 0 0 0",
               O_word_ready, O_cfg_data_valid, O_cfg_data_last, O_word_done, O_cfg_data, O_word_cnt);
    end
  endtask

  task automatic test_flow();
    logic [511:0] w = {{32{4'hA}}, {32{4'hB}}, {32{4'hC}}, {32{4'hD}}};
    checks++;
    if (O_word_ready !== 1'b1) begin failures++; $display("FAIL flow_idle: rdy=%b want 1", O_word_ready); end
    I_word_value = w; I_word_valid = 1; I_cfg_data_ready = 1;
    tick();
    I_word_valid = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (O_cfg_data_valid !== 1'b1 || O_cfg_data !== beat(w, k) || O_cfg_data_last !== (k == 3) ||
          O_word_ready !== 1'b0 || O_word_done !== 1'b0) begin
        failures++;
        $display("FAIL flow_beat%0d: vld=%b data=%h last=%b rdy=%b done=%b, want 1 %h %b 0 0",
                 k, O_cfg_data_valid, O_cfg_data, O_cfg_data_last, O_word_ready, O_word_done, beat(w, k), k == 3);
      end
      tick();
    end
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    checks++;
    if (O_word_done !== 1'b1 || O_cfg_data_valid !== 1'b0 || O_word_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("FAIL flow_done: done=%b vld=%b cnt=%0d, want 1 0 %0d", O_word_done, O_cfg_data_valid, O_word_cnt, exp_cnt);
    end
    tick();
    checks++;
    if (O_word_ready !== 1'b1 || O_word_done !== 1'b0) begin
      failures++;
      $display("FAIL flow_back_idle: rdy=%b done=%b, want 1 0", O_word_ready, O_word_done);
    end
  endtask

  // one word with a given number of stall cycles in front of each beat's acceptance
  task automatic test_backpressure(input logic [511:0] w, input int s0, input int s1, input int s2, input int s3);
    int st[4];
    int cyc;
    st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
    checks++;
    if (O_word_ready !== 1'b1) begin failures++; $display("FAIL bp_idle: rdy=%b want 1", O_word_ready); end
    I_word_value = w; I_word_valid = 1; I_cfg_data_ready = $urandom_range(0, 1);
    tick();
    cyc = 1;
    I_word_valid = 0; I_word_value = rand_word();
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s <= st[k]; s++) begin
        I_cfg_data_ready = (s == st[k]);
        checks++;
        if (O_cfg_data_valid !== 1'b1 || O_cfg_data !== beat(w, k) || O_cfg_data_last !== (k == 3) ||
            O_word_ready !== 1'b0 || O_word_done !== 1'b0) begin
          failures++;
          $display("FAIL bp_beat%0d_stall%0d: vld=%b data=%h last=%b rdy=%b done=%b, want 1 %h %b 0 0",
                   k, s, O_cfg_data_valid, O_cfg_data, O_cfg_data_last, O_word_ready, O_word_done, beat(w, k), k == 3);
        end
        tick();
        cyc++;
      end
    end
    I_cfg_data_ready = $urandom_range(0, 1);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    checks++;
    if (O_word_done !== 1'b1 || O_cfg_data_valid !== 1'b0 || O_word_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("FAIL bp_done: done=%b vld=%b cnt=%0d, want 1 0 %0d", O_word_done, O_cfg_data_valid, O_word_cnt, exp_cnt);
    end
    tick();
    cyc++;
    checks++;
    if (O_word_ready !== 1'b1 || O_word_done !== 1'b0 || cyc != 6 + s0 + s1 + s2 + s3) begin
      failures++;
      $display("FAIL bp_period: rdy=%b done=%b period=%0d, want 1 0 %0d", O_word_ready, O_word_done, cyc, 6 + s0 + s1 + s2 + s3);
    end
  endtask

  task automatic test_abort();
    logic [511:0] w = rand_word();
    I_word_value = w; I_word_valid = 1; I_cfg_data_ready = 1;
    tick();
    I_word_valid = 0;
    tick();
    tick();
    checks++;
    if (O_cfg_data !== beat(w, 2)) begin failures++; $display("FAIL abort_beatc: data=%h want %h", O_cfg_data, beat(w, 2)); end
    I_clr = 1;
    tick();
    I_clr = 0;
    exp_cnt = 0;
    checks++;
    if (O_cfg_data_valid !== 1'b0 || O_word_ready !== 1'b1 || O_word_cnt !== CW'(0) ||
        O_word_done !== 1'b0 || O_cfg_data !== 128'h0) begin
      failures++;
      $display("FAIL abort_state: vld=%b rdy=%b cnt=%0d done=%b data=%h, want 0 1 0 0 0",
               O_cfg_data_valid, O_word_ready, O_word_cnt, O_word_done, O_cfg_data);
    end
    I_clr = 1; I_word_valid = 1; I_word_value = rand_word();
    tick();
    I_clr = 0; I_word_valid = 0;
    checks++;
    if (O_cfg_data_valid !== 1'b0 || O_word_ready !== 1'b1 || O_word_done !== 1'b0) begin
      failures++;
      $display("FAIL clr_blocks_accept: vld=%b rdy=%b done=%b, want 0 1 0", O_cfg_data_valid, O_word_ready, O_word_done);
    end
    test_backpressure(rand_word(), 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    I_clr = 1;
    tick();
    I_clr = 0;
    exp_cnt = 0;
    for (int i = 0; i < 17; i++) test_backpressure(rand_word(), 0, $urandom_range(0, 1), 0, 0);
    checks++;
    if (O_word_cnt !== CW'(1)) begin failures++; $display("FAIL wrap_cnt: cnt=%0d want 1", O_word_cnt); end
  endtask

  task automatic test_reset_mid();
    I_word_value = rand_word(); I_word_valid = 1; I_cfg_data_ready = 1;
    tick();
    I_word_valid = 0;
    tick();
    #2 I_sys_rst_n = 0;
    #1;
    exp_cnt = 0;
    test_reset();
    tick();
    tick();
    I_sys_rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (O_word_done !== 1'b0 || O_word_ready !== 1'b1 || O_word_cnt !== CW'(0)) begin
        failures++;
        $display("FAIL rst_release%0d: done=%b rdy=%b cnt=%0d, want 0 1 0", i, O_word_done, O_word_ready, O_word_cnt);
      end
    end
    test_backpressure(rand_word(), 0, 0, 0, 0);
  endtask

  task automatic test_ignored_valid();
    logic [511:0] w1 = rand_word();
    logic [511:0] w2 = rand_word();
    I_word_value = w1; I_word_valid = 1; I_cfg_data_ready = 1;
    tick();
    I_word_value = w2;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (O_word_ready !== 1'b0 || O_cfg_data !== beat(w1, k)) begin
        failures++;
        $display("FAIL ign_w1_beat%0d: rdy=%b data=%h, want 0 %h", k, O_word_ready, O_cfg_data, beat(w1, k));
      end
      tick();
    end
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    checks++;
    if (O_word_done !== 1'b1 || O_word_ready !== 1'b0) begin
      failures++;
      $display("FAIL ign_done: done=%b rdy=%b, want 1 0", O_word_done, O_word_ready);
    end
    tick();
    checks++;
    if (O_word_ready !== 1'b1 || O_cfg_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL ign_idle: rdy=%b vld=%b, want 1 0", O_word_ready, O_cfg_data_valid);
    end
    tick();
    I_word_valid = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (O_cfg_data_valid !== 1'b1 || O_cfg_data !== beat(w2, k)) begin
        failures++;
        $display("FAIL ign_w2_beat%0d: vld=%b data=%h, want 1 %h", k, O_cfg_data_valid, O_cfg_data, beat(w2, k));
      end
      tick();
    end
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    checks++;
    if (O_word_done !== 1'b1 || O_word_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("FAIL ign_w2_done: done=%b cnt=%0d, want 1 %0d", O_word_done, O_word_cnt, exp_cnt);
    end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    tick();
    tick();
    I_sys_rst_n = 1;
    tick();
    test_reset();
    test_flow();
    test_backpressure(rand_word(), 0, 3, 0, 0);
    for (int i = 0; i < 20; i++)
      test_backpressure(rand_word(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    test_abort();
    test_wrap();
    test_reset_mid();
    test_ignored_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
